// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // Upper nibble of every packet header byte.
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  // Header byte announcing which source owns the following packet.
  function automatic logic [7:0] build_header(input logic [3:0] id);
    return {HDR_MAGIC, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: searches req from ptr+1 upward,
// wrapping modulo NUM_REQ, and returns the first set index.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] idx_s;
  logic             hit_s;

  // Walk the candidates in rotated order; the first hit locks the grant.
  always_comb begin
    grant   = {IDX_W{1'b0}};
    any_req = 1'b0;
    idx_s   = {IDX_W{1'b0}};
    hit_s   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s   = IDX_W'((int'(ptr) + i) % NUM_REQ);
      hit_s   = !any_req && req[idx_s];
      grant   = hit_s ? idx_s : grant;
      any_req = any_req | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-serial UART transmitter among NUM_REQ packet sources.
// Grants are round-robin at packet boundaries; each packet may be preceded
// by a source-ID header byte. A watchdog forces completion if the
// transmitter never reports done.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int HEADER_EN  = 1,
  parameter int TX_TIMEOUT = 100_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [3:0]             grant_id,
  output logic                   timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TX_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] grant_idx_r;
  logic             busy_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;
  logic             hdr_phase_r;
  logic             last_q_r;
  logic [WD_W-1:0]  wd_cnt_r;
  logic             timeout_err_r;

  logic [IDX_W-1:0] arb_grant_s;
  logic             arb_any_s;
  logic             sel_valid_s;
  logic [7:0]       sel_data_s;
  logic             sel_last_s;
  logic             done_s;
  logic             wd_hit_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_r),
    .grant   (arb_grant_s),
    .any_req (arb_any_s)
  );

  // Route the granted source to the byte path; only it may see ready, and only in SEND.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = 8'h00;
    sel_last_s  = 1'b0;
    req_ready   = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_valid_s  = sel_valid_s | ((grant_idx_r == IDX_W'(i)) & req_valid[i]);
      sel_data_s   = sel_data_s | ({8{grant_idx_r == IDX_W'(i)}} & req_data[8*i +: 8]);
      sel_last_s   = sel_last_s | ((grant_idx_r == IDX_W'(i)) & req_last[i]);
      req_ready[i] = (state_r == ST_SEND) & (grant_idx_r == IDX_W'(i)) & req_valid[i];
    end
  end

  // A done pulse coinciding with our own tx_valid belongs to the previous byte.
  assign done_s   = tx_done & ~tx_valid_r;
  assign wd_hit_s = (wd_cnt_r == WD_LIMIT);

  // Arbitration FSM, watchdog and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= PTR_RESET;
      grant_idx_r   <= {IDX_W{1'b0}};
      busy_r        <= 1'b0;
      tx_valid_r    <= 1'b0;
      tx_data_r     <= 8'h00;
      hdr_phase_r   <= 1'b0;
      last_q_r      <= 1'b0;
      wd_cnt_r      <= {WD_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      tx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            grant_idx_r <= arb_grant_s;
            busy_r      <= 1'b1;
            if (HEADER_EN != 0) begin
              tx_valid_r  <= 1'b1;
              tx_data_r   <= build_header(4'(arb_grant_s));
              hdr_phase_r <= 1'b1;
              wd_cnt_r    <= {WD_W{1'b0}};
              state_r     <= ST_WAIT_DONE;
            end else begin
              state_r <= ST_SEND;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (sel_valid_s) begin
            tx_valid_r  <= 1'b1;
            tx_data_r   <= sel_data_s;
            last_q_r    <= sel_last_s;
            hdr_phase_r <= 1'b0;
            wd_cnt_r    <= {WD_W{1'b0}};
            state_r     <= ST_WAIT_DONE;
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_WAIT_DONE: begin
          if (done_s || wd_hit_s) begin
            timeout_err_r <= timeout_err_r | wd_hit_s;
            wd_cnt_r      <= {WD_W{1'b0}};
            if (hdr_phase_r || !last_q_r) begin
              state_r <= ST_SEND;
            end else begin
              state_r <= ST_IDLE;
              ptr_r   <= grant_idx_r;
              busy_r  <= 1'b0;
            end
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid    = tx_valid_r;
  assign tx_data     = tx_data_r;
  assign busy        = busy_r;
  assign grant_id    = 4'(grant_idx_r);
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, scoreboard-based bench for uart_tx_arbiter.
// dut_a: header mode with a short watchdog; dut_b: headerless mode.
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic [3:0] gid;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // dut_a signals
  logic [1:0]  a_req_valid;
  logic [15:0] a_req_data;
  logic [1:0]  a_req_last;
  logic [1:0]  a_req_ready;
  logic        a_tx_valid;
  logic [7:0]  a_tx_data;
  logic        a_tx_done = 1'b0;
  logic        a_busy;
  logic [3:0]  a_grant_id;
  logic        a_timeout_err;

  // dut_b signals
  logic [1:0]  b_req_valid = 2'b00;
  logic [15:0] b_req_data = 16'h0000;
  logic [1:0]  b_req_last = 2'b00;
  logic [1:0]  b_req_ready;
  logic        b_tx_valid;
  logic [7:0]  b_tx_data;
  logic        b_tx_done = 1'b0;
  logic        b_busy;
  logic [3:0]  b_grant_id;
  logic        b_timeout_err;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // source models
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [1:0] src_en = 2'b11;
  logic [1:0] have = 2'b00;
  logic [7:0] front0 = 8'h00;
  logic [7:0] front1 = 8'h00;
  logic       last0 = 1'b0;
  logic       last1 = 1'b0;
  logic [1:0] hs_r;
  int         hs_cnt[2];

  // transmitter model and monitors
  logic done_en = 1'b1;
  int   dcnt = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];
  int   txv_cnt = 0;
  logic prev_v = 1'b0;
  int   b_txv_cnt = 0;

  assign a_req_valid = src_en & have;
  assign a_req_data  = {front1, front0};
  assign a_req_last  = {last1, last0};

  uart_tx_arbiter #(.NUM_REQ(2), .HEADER_EN(1), .TX_TIMEOUT(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_last(a_req_last), .req_ready(a_req_ready), .tx_valid(a_tx_valid),
    .tx_data(a_tx_data), .tx_done(a_tx_done), .busy(a_busy),
    .grant_id(a_grant_id), .timeout_err(a_timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(2), .HEADER_EN(0), .TX_TIMEOUT(100_000)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_last(b_req_last), .req_ready(b_req_ready), .tx_valid(b_tx_valid),
    .tx_data(b_tx_data), .tx_done(b_tx_done), .busy(b_busy),
    .grant_id(b_grant_id), .timeout_err(b_timeout_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // record handshakes seen at the active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_r <= 2'b00;
    else        hs_r <= a_req_ready & a_req_valid;
  end

  // source model: pop accepted bytes, present the next one
  always @(negedge clk) begin
    if (hs_r[0] && src_q0.size() > 0) begin
      void'(src_q0.pop_front());
      hs_cnt[0]++;
    end
    if (hs_r[1] && src_q1.size() > 0) begin
      void'(src_q1.pop_front());
      hs_cnt[1]++;
    end
    have[0] = (src_q0.size() > 0);
    have[1] = (src_q1.size() > 0);
    front0  = have[0] ? src_q0[0][7:0] : 8'h00;
    last0   = have[0] ? src_q0[0][8]   : 1'b0;
    front1  = have[1] ? src_q1[0][7:0] : 8'h00;
    last1   = have[1] ? src_q1[0][8]   : 1'b0;
  end

  // transmitter model: done pulse 10 cycles after each tx_valid
  always @(negedge clk) begin
    a_tx_done = 1'b0;
    if (!rst_n) begin
      dcnt = 0;
    end else if (a_tx_valid) begin
      dcnt = 10;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && done_en) begin
        a_tx_done = 1'b1;
        done_cnt++;
      end
    end
  end

  // scoreboard monitor for dut_a
  always @(negedge clk) begin
    if (rst_n && a_tx_valid) begin
      exp_t e;
      txv_cnt++;
      chk("pulse_width", 32'(prev_v), 32'd0);
      chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("tx_data", 32'(a_tx_data), 32'(e.data));
        chk("grant_id", 32'(a_grant_id), 32'(e.gid));
      end
    end
    prev_v = a_tx_valid;
  end

  // tx_valid pulse counter for dut_b
  always @(negedge clk) begin
    if (b_tx_valid) b_txv_cnt++;
  end

  task automatic load_src(input int src, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
      if (src == 0) src_q0.push_back({(i == n - 1), b});
      else          src_q1.push_back({(i == n - 1), b});
    end
  endtask

  task automatic exp_pkt(input int src, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n);
    exp_t e;
    e.gid  = 4'(src);
    e.data = {4'hA, 4'(src)};
    sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.data = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (sb_q.size() != 0 || a_busy || src_q0.size() != 0 || src_q1.size() != 0)) begin
      tick();
      k++;
    end
    chk(tag, 32'(k < 3000), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_valid"}, 32'(a_tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(a_tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(a_grant_id), 32'd0);
    chk({tag, "_timeout_err"}, 32'(a_timeout_err), 32'd0);
    chk({tag, "_req_ready"}, 32'(a_req_ready), 32'd0);
  endtask

  initial begin
    int k, h, d0, t0, c0, c1, bad_v, bad_g, bad_r, bad_b;

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outs("rst");
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // single 3-byte packet from source 0 with header
    d0 = done_cnt; t0 = txv_cnt; h = hs_cnt[0];
    exp_pkt(0, 8'h11, 8'h22, 8'h33, 3);
    load_src(0, 8'h11, 8'h22, 8'h33, 3);
    k = 0;
    while (k < 5 && !a_req_valid[0]) begin tick(); k++; end
    chk("t1_req_seen", 32'(a_req_valid[0]), 32'd1);
    tick();
    chk("t1_hdr_latency", 32'(a_tx_valid), 32'd1);
    chk("t1_hdr_data", 32'(a_tx_data), 32'hA0);
    chk("t1_busy", 32'(a_busy), 32'd1);
    k = 0;
    while (k < 500 && done_cnt < d0 + 4) begin tick(); k++; end
    chk("t1_done4", 32'(done_cnt - d0), 32'd4);
    chk("t1_busy_at_done", 32'(a_busy), 32'd1);
    tick();
    chk("t1_busy_cleared", 32'(a_busy), 32'd0);
    chk("t1_ready_pulses", 32'(hs_cnt[0] - h), 32'd3);
    chk("t1_tx_pulses", 32'(txv_cnt - t0), 32'd4);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // two sources, alternating single-byte packets after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pkt(0, 8'h01, 8'h00, 8'h00, 1);
    exp_pkt(1, 8'h81, 8'h00, 8'h00, 1);
    exp_pkt(0, 8'h02, 8'h00, 8'h00, 1);
    exp_pkt(1, 8'h82, 8'h00, 8'h00, 1);
    load_src(0, 8'h01, 8'h00, 8'h00, 1);
    load_src(0, 8'h02, 8'h00, 8'h00, 1);
    load_src(1, 8'h81, 8'h00, 8'h00, 1);
    load_src(1, 8'h82, 8'h00, 8'h00, 1);
    wait_drain("t2_drain");

    // granted source 1 stalls mid-packet while source 0 waits
    h = hs_cnt[1];
    exp_pkt(1, 8'h91, 8'h92, 8'h00, 2);
    exp_pkt(0, 8'h31, 8'h00, 8'h00, 1);
    load_src(1, 8'h91, 8'h92, 8'h00, 2);
    k = 0;
    while (k < 200 && hs_cnt[1] < h + 1) begin tick(); k++; end
    chk("t3_first_byte", 32'(hs_cnt[1] - h), 32'd1);
    src_en[1] = 1'b0;
    load_src(0, 8'h31, 8'h00, 8'h00, 1);
    bad_v = 0; bad_g = 0; bad_r = 0; bad_b = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_tx_valid)          bad_v++;
      if (a_grant_id != 4'd1)  bad_g++;
      if (a_req_ready[0])      bad_r++;
      if (!a_busy)             bad_b++;
    end
    chk("t3_gap_tx_valid", 32'(bad_v), 32'd0);
    chk("t3_gap_grant", 32'(bad_g), 32'd0);
    chk("t3_gap_ready0", 32'(bad_r), 32'd0);
    chk("t3_gap_busy", 32'(bad_b), 32'd0);
    src_en[1] = 1'b1;
    wait_drain("t3_drain");

    // watchdog: transmitter never answers
    chk("t4_err_before", 32'(a_timeout_err), 32'd0);
    done_en = 1'b0;
    exp_pkt(0, 8'h44, 8'h45, 8'h00, 2);
    load_src(0, 8'h44, 8'h45, 8'h00, 2);
    k = 0;
    while (k < 10 && !a_tx_valid) begin tick(); k++; end
    chk("t4_hdr_issued", 32'(a_tx_valid), 32'd1);
    c0 = cyc;
    k = 0;
    while (k < 200 && !a_timeout_err) begin tick(); k++; end
    c1 = cyc;
    chk("t4_timeout_delay", 32'(c1 - c0), 32'd64);
    done_en = 1'b1;
    wait_drain("t4_drain");
    chk("t4_err_sticky", 32'(a_timeout_err), 32'd1);

    // async reset in the middle of a packet
    h = hs_cnt[0];
    exp_pkt(0, 8'h51, 8'h52, 8'h53, 3);
    load_src(0, 8'h51, 8'h52, 8'h53, 3);
    k = 0;
    while (k < 200 && hs_cnt[0] < h + 2) begin tick(); k++; end
    chk("t5_second_byte", 32'(hs_cnt[0] - h), 32'd2);
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t5_async");
    chk("t5_sb_left", 32'(sb_q.size()), 32'd1);
    sb_q.delete();
    src_q0.delete();
    src_q1.delete();
    tick();
    exp_pkt(0, 8'h71, 8'h00, 8'h00, 1);
    exp_pkt(1, 8'h72, 8'h00, 8'h00, 1);
    load_src(0, 8'h71, 8'h00, 8'h00, 1);
    load_src(1, 8'h72, 8'h00, 8'h00, 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_first_grant", 32'(a_grant_id), 32'd0);
    chk("t5_busy", 32'(a_busy), 32'd1);
    chk("t5_err_cleared", 32'(a_timeout_err), 32'd0);
    wait_drain("t5_drain");

    // headerless instance: one byte, no header
    t0 = b_txv_cnt;
    b_req_valid = 2'b01;
    b_req_data  = 16'h005C;
    b_req_last  = 2'b01;
    tick();
    chk("t6_no_early_tx", 32'(b_tx_valid), 32'd0);
    chk("t6_busy", 32'(b_busy), 32'd1);
    chk("t6_ready", 32'(b_req_ready), 32'd1);
    tick();
    chk("t6_tx_valid", 32'(b_tx_valid), 32'd1);
    chk("t6_tx_data", 32'(b_tx_data), 32'h5C);
    b_req_valid = 2'b00;
    tick();
    chk("t6_pulse_end", 32'(b_tx_valid), 32'd0);
    b_tx_done = 1'b1;
    tick();
    b_tx_done = 1'b0;
    chk("t6_busy_cleared", 32'(b_busy), 32'd0);
    repeat (5) tick();
    chk("t6_pulse_count", 32'(b_txv_cnt - t0), 32'd1);
    chk("t6_data_held", 32'(b_tx_data), 32'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART transmitter among NUM_REQ packet sources, e.g. solver result streamer and debug/echo path.
- Grants sources round-robin at packet boundaries and optionally prefixes each packet with a source-ID header byte.
- Issues one byte at a time to the transmitter with a one-cycle valid pulse, then waits for its done pulse.
- A watchdog keeps a hung transmitter from locking the bus.

Parameters:
- NUM_REQ, 2, number of requesters (1..16).
- HEADER_EN, 1, 1 = send header byte {4'hA, id[3:0]} before each packet.
- TX_TIMEOUT, 100_000, cycles to wait for tx_done before forcing completion.

Ports:
- clk  input  1  system clock (transmitter clock domain).
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-source byte available.
- req_data  input  8*NUM_REQ  per-source byte; source i on bits [8i+7:8i].
- req_last  input  NUM_REQ  per-source byte is last of packet.
- req_ready  output  NUM_REQ  per-source byte accepted this cycle.
- tx_valid  output  1  one-cycle start pulse to transmitter.
- tx_data  output  8  byte to transmit; held stable until the next tx_valid.
- tx_done  input  1  transmitter finished current byte (one-cycle pulse).
- busy  output  1  packet in progress.
- grant_id  output  4  current granted source; meaningful while busy.
- timeout_err  output  1  sticky; set on any watchdog expiry.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; tx_valid=0, tx_data=0, busy=0, grant_id=0, timeout_err=0, req_ready=0.
  - RR pointer=NUM_REQ-1, so source 0 wins first.
  - Reset mid-packet abandons the packet silently; no partial header is re-sent.
- States: IDLE, SEND, WAIT_DONE (2-bit encoding).
- IDLE:
  - If any req_valid is set, pick the first set bit searching from pointer+1 modulo NUM_REQ.
  - Register grant_id, set busy=1.
  - HEADER_EN=1: register tx_valid=1, tx_data={4'hA,id}, hdr_phase=1, go WAIT_DONE.
  - HEADER_EN=0: go SEND.
  - req_valid is only sampled, never acknowledged, in IDLE.
- SEND:
  - req_ready[grant_id] = req_valid[grant_id], combinational. All other req_ready bits are 0.
  - On handshake, register tx_valid=1, tx_data=byte, last_q=req_last, hdr_phase=0, then go WAIT_DONE.
  - If the granted source drops valid, wait indefinitely with the grant held; other sources are ignored.
- WAIT_DONE:
  - tx_valid returns to 0 one cycle after assertion, so the pulse is exactly one cycle.
  - Watchdog counter clears on entry and increments each cycle.
  - tx_done is ignored in the cycle tx_valid is high (treated as stale).
  - Completion is tx_done=1, or watchdog reaching TX_TIMEOUT-1. A timeout also sets timeout_err.
  - On completion:
    - hdr_phase=1 → SEND.
    - last_q=0 → SEND.
    - last_q=1 → IDLE, pointer=grant_id, busy=0 in the next cycle.
- tx_done outside WAIT_DONE: ignored.
- Latency:
  - Request to first tx_valid is 1 cycle with header.
  - Without header it is 2 cycles: IDLE→SEND, then handshake.
  - tx_done to next tx_valid is 2 cycles when the source is already valid (transition to SEND, then registered tx_valid).
- NUM_REQ=1: arbitration is trivial; grant_id=0 always.
- timeout_err clears only on reset.

Decomposition:
- Package uart_arb_pkg:
  - state enum.
  - HDR_MAGIC=4'hA.
  - function build_header(id).
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, pointer.
  - Outputs: grant index and any_req.
  - Purely combinational rotate-priority pick.
- FSM, watchdog and registers remain in uart_tx_arbiter.

Test Plan:
- HEADER_EN=1; source 0 sends {8'h11,8'h22,8'h33}, last on 33; tx model pulses done 10 cycles after each tx_valid → tx_data sequence A0,11,22,33; four single-cycle tx_valid pulses; req_ready[0] pulses 3 times; busy low 1 cycle after 4th done.
- Sources 0 and 1 both valid with 1-byte packets from reset release, repeated twice → headers in order A0,A1,A0,A1; grant never changes mid-packet.
- Source 1 granted, drops req_valid for 50 cycles after first byte while source 0 stays valid → no tx_valid during gap, grant_id stays 1, req_ready[0]=0 throughout.
- TX_TIMEOUT=64, tx_done never asserted → timeout_err rises 64 cycles after tx_valid; next byte issued and stays sticky.
- rst_n pulled low during WAIT_DONE of byte 2 → all outputs 0 immediately without clock; after release with both sources valid, source 0 granted first, timeout_err=0.
- HEADER_EN=0, source 0 single byte 8'h5C with last → exactly one tx_valid, tx_data=5C, no header byte, busy clears after done.
